// File: rtl/slide_match_gen.sv
// Sliding-distance sample matcher: compares each accepted sample with the one DISTANCE
// accepted samples earlier, emits hit/hit_en and a run-length lock flag. Optional: SLIDE_MATCH_STATS_EN.
module slide_match_gen #(
   parameter int DATA_W   = 32,
   parameter int DISTANCE = 16,
   parameter int RUN_TH   = 8,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              clear,
   output logic              hit_en,
   output logic              hit,
   output logic [CNT_W-1:0]  run_len,
   output logic              loop_lock,
   output logic [1:0]        state
`ifdef SLIDE_MATCH_STATS_EN
   ,
   output logic [CNT_W-1:0]  hit_total
`endif
);

   // Handshake: a sample is taken on every rising edge where in_valid=1 and clear=0; there
   // is no back-pressure. hit_en/hit report that sample exactly one cycle later.

   localparam int FILL_W = $clog2(DISTANCE + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DISTANCE);
   localparam logic [CNT_W-1:0]  RUN_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  RUN_THR  = CNT_W'(RUN_TH);

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOCK   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [CNT_W-1:0]  run_d;
   logic [DATA_W-1:0] hist [DISTANCE];
   logic              accepted;
   logic              fill_full;
   logic              match;

   assign accepted  = in_valid && !clear;
   assign fill_full = (fill_q == FILL_MAX);
   // hist[DISTANCE-1] is read before this edge's shift, i.e. DISTANCE samples back.
   assign match     = accepted && fill_full && (in_data == hist[DISTANCE-1]);

   always_comb begin
      fill_d = fill_q;
      run_d  = run_len;
      if (accepted) begin
         if (!fill_full)
            fill_d = fill_q + FILL_W'(1);
         if (match)
            run_d = (run_len == RUN_MAX) ? run_len : run_len + CNT_W'(1);
         else
            run_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FILL:   if (accepted && fill_d == FILL_MAX) state_d = ST_SEARCH;
         ST_SEARCH: if (match && run_d >= RUN_THR)      state_d = ST_LOCK;
         ST_LOCK:   if (accepted && !match)             state_d = ST_SEARCH;
         default:   state_d = ST_FILL;
      endcase
      if (clear)
         state_d = ST_FILL;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FILL;
         fill_q  <= '0;
         run_len <= '0;
         hit_en  <= 1'b0;
         hit     <= 1'b0;
      end else begin
         state_q <= state_d;
         hit_en  <= accepted;
         hit     <= match;
         if (clear) begin
            fill_q  <= '0;
            run_len <= '0;
         end else begin
            fill_q  <= fill_d;
            run_len <= run_d;
         end
      end
   end

   // History contents are don't-care after reset; only fill_q qualifies them.
   always_ff @(posedge clk) begin
      if (accepted) begin
         hist[0] <= in_data;
         for (int i = 1; i < DISTANCE; i++)
            hist[i] <= hist[i-1];
      end
   end

   assign loop_lock = (state_q == ST_LOCK);
   assign state     = state_q;

`ifdef SLIDE_MATCH_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         hit_total <= '0;
      else if (clear)
         hit_total <= '0;
      else if (match && hit_total != RUN_MAX)
         hit_total <= hit_total + CNT_W'(1);
   end
`endif

endmodule

// File: doc/slide_match_gen.md
Name: slide_match_gen

Overview:
Upstream stage of the sliding-vector loop detector. It keeps a history of the last DISTANCE valid samples of an input stream (e.g. PCs or branch targets) and compares each new sample against the sample DISTANCE positions back. For each accepted sample it emits a registered hit/strobe pair: hit drives the slide vector's `in`, and hit_en drives its `clk_en`. It also tracks consecutive matches and raises a loop-lock flag once a run threshold is met.

Parameters:
DATA_W, 32, width of a stream sample
DISTANCE, 16, compare distance in valid samples (equals the downstream VECTOR_SIZE); must be >= 2
RUN_TH, 8, consecutive matches required for lock; 1 <= RUN_TH <= 2^CNT_W-1
CNT_W, 16, width of run_len (and of hit_total when enabled)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  sample strobe
in_data  in  DATA_W  sample value
clear  in  1  synchronous flush, one-cycle pulse or level
hit_en  out  1  registered copy of in_valid; downstream clk_en
hit  out  1  registered match result; downstream in
run_len  out  CNT_W  current consecutive-match count
loop_lock  out  1  high while in LOCK state
state  out  2  FSM state: FILL=0, SEARCH=1, LOCK=2 (3 unused, recovers to FILL)

Behaviour:
- Reset (reset=0, asynchronous): fill count=0, run_len=0, state=FILL, hit_en=0, hit=0, loop_lock=0. History contents are don't-care.
- History: DISTANCE-entry shift buffer that shifts only on accepted samples. Entry 0 is the newest sample; entry DISTANCE-1 is the oldest.
- Accepted sample: in_valid=1 and clear=0.
- Fill counter: 0..DISTANCE. Increments on each accepted sample and saturates at DISTANCE.
- match: accepted, fill==DISTANCE, and in_data==hist[DISTANCE-1]. The comparison uses pre-shift contents, i.e. the sample exactly DISTANCE accepted samples earlier.
- Latency: 1 cycle. hit_en(t+1)=accepted(t), hit(t+1)=match(t). hit is never 1 while hit_en is 0. Both outputs are 0 in idle cycles.
- run_len, updated on accepted samples only:
  - match: increment, saturating at 2^CNT_W-1.
  - non-match: reset to 0.
  - No change when no sample is accepted.
- FSM, evaluated on accepted samples only:
  - FILL to SEARCH on the sample that brings fill to DISTANCE. That sample is not compared; the next one is the first compared.
  - SEARCH to LOCK when the next run_len value is >= RUN_TH.
  - LOCK to SEARCH on a non-match. run_len goes to 0 in the same cycle.
  - LOCK holds through matches and idle cycles.
- loop_lock = (state==LOCK). It updates in the same edge as run_len, so it is visible the cycle after the qualifying sample.
- clear=1 (synchronous): fill=0, run_len=0, state=FILL, hit_en=0, hit=0 on the next edge.
  - clear dominates in_valid; the concurrent sample is dropped and the history does not shift.
- Gaps in in_valid are transparent: distance is counted in accepted samples, not cycles.
- Reset asserted mid-stream: all state returns to reset values immediately. The fill phase restarts after deassertion.

Optional Feature:
SLIDE_MATCH_STATS_EN
- Defined: adds output port hit_total [CNT_W-1:0].
  - Counts registered hits (+1 per cycle with match).
  - Saturates at 2^CNT_W-1.
  - Cleared by reset or clear; not cleared by lock loss.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- DISTANCE=4, RUN_TH=3; stream 1,2,3,4,1,2,3,4,1 on consecutive cycles -> hit_en=1 for 9 cycles, each 1 cycle after its input. hit=0 for samples 1-4, hit=1 for samples 5-9. run_len=1,2,3,4,5. state FILL->SEARCH after sample 4. loop_lock=1 from the cycle after sample 7.
- Locked stream, then sample 9 instead of the expected 2 -> hit=0, run_len=0, state=SEARCH, loop_lock=0 the next cycle. Following periodic samples (now mismatching the 9 in history) re-accumulate correctly.
- Same period-4 stream with 0-3 idle cycles inserted between samples -> identical hit/run_len sequence on hit_en cycles. hit_en=0 and hit=0 on idle cycles.
- clear asserted together with in_valid (data=1) while in LOCK -> next cycle state=FILL, run_len=0, hit_en=0. The dropped sample is not counted in fill: 4 further samples are needed before the first compare.
- CNT_W=3, RUN_TH=2, constant stream of 5 -> run_len saturates at 7 and holds. loop_lock stays 1. With SLIDE_MATCH_STATS_EN, hit_total saturates at 7.
- reset driven low asynchronously mid-cycle during LOCK -> all outputs 0 and state=FILL immediately (no clock edge needed). After release, the fill phase restarts from 0.
